// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_pkg
// Description : Shared state encoding and counter sizing for serial_subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A one-bit counter is still needed when WIDTH is 1 or 2.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_complete_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : complete_subtractor
// Description : Combinational one-bit full-subtractor cell (x - y - b_in).
// Revision    : 1.0 - initial release
// ============================================================================
module complete_subtractor (
    output logic d,
    output logic b_out,
    input  logic b_in,
    input  logic x,
    input  logic y
);

    assign d     = x ^ y ^ b_in;
    assign b_out = (~x & y) | (~(x ^ y) & b_in);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial a - b, one bit per clock, start/ready + done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int                 c_cnt_w = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_borrow;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_a_msb;
    logic               r_b_msb;

    logic               w_d;
    logic               w_bout;
    logic               w_load;
    logic               w_shift;
    logic [WIDTH-1:0]   w_res_next;

    assign w_load  = (r_state == ST_IDLE) && start;
    assign w_shift = (r_state == ST_SHIFT);

    complete_subtractor u_cell (
        .d     (w_d),
        .b_out (w_bout),
        .b_in  (r_borrow),
        .x     (r_a[0]),
        .y     (r_b[0])
    );

    // Partial result keeps only the upper WIDTH-1 bits; the current cell
    // output supplies the MSB of the completed word.
    generate
        if (WIDTH > 1) begin : g_part
            logic [WIDTH-2:0] r_part;

            always_ff @(posedge clk) begin
                if (rst || w_load) begin
                    r_part <= '0;
                end else if (w_shift) begin
                    r_part <= w_res_next[WIDTH-1:1];
                end
            end

            assign w_res_next = {w_d, r_part};
        end else begin : g_no_part
            assign w_res_next = w_d;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            ready      <= 1'b1;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_borrow   <= 1'b0;
            r_cnt      <= '0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_a_msb  <= a[WIDTH-1];
                        r_b_msb  <= b[WIDTH-1];
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        ready    <= 1'b0;
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last) begin
                        diff       <= w_res_next;
                        borrow_out <= w_bout;
                        overflow   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
                        done       <= 1'b1;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor at WIDTH 8, 3 and 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       st  [3];
    logic [7:0] av  [3];
    logic [7:0] bv  [3];
    logic       rdy [3];
    logic       dn  [3];
    logic       bo  [3];
    logic       ov  [3];
    logic [7:0] dv  [3];
    logic [7:0] d8;
    logic [2:0] d3;
    logic [0:0] d1;

    int checks   = 0;
    int failures = 0;

    // Reference model: cycles remaining until ready, plus expected outputs.
    int         m_left [3];
    int         m_a    [3];
    int         m_b    [3];
    logic [7:0] m_diff [3];
    logic       m_bo   [3];
    logic       m_ov   [3];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(st[0]), .a(av[0]), .b(bv[0]),
        .ready(rdy[0]), .done(dn[0]), .diff(d8), .borrow_out(bo[0]), .overflow(ov[0])
    );
    serial_subtractor #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(st[1]), .a(av[1][2:0]), .b(bv[1][2:0]),
        .ready(rdy[1]), .done(dn[1]), .diff(d3), .borrow_out(bo[1]), .overflow(ov[1])
    );
    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(st[2]), .a(av[2][0:0]), .b(bv[2][0:0]),
        .ready(rdy[2]), .done(dn[2]), .diff(d1), .borrow_out(bo[2]), .overflow(ov[2])
    );

    assign dv[0] = d8;
    assign dv[1] = {5'd0, d3};
    assign dv[2] = {7'd0, d1};

    function automatic int wid(input int i);
        return (i == 0) ? 8 : (i == 1) ? 3 : 1;
    endfunction

    function automatic int sval(input int v, input int w);
        return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t got=%0h expected=%0h", name, idx, $time, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout t=%0t", name, $time);
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int w;
            int sd;
            w = wid(i);
            if (rst) begin
                m_left[i] = 0;
                m_diff[i] = '0;
                m_bo[i]   = 1'b0;
                m_ov[i]   = 1'b0;
            end else if (m_left[i] == 0) begin
                if (st[i] === 1'b1) begin
                    m_a[i]    = int'(av[i]) & ((1 << w) - 1);
                    m_b[i]    = int'(bv[i]) & ((1 << w) - 1);
                    m_left[i] = w + 1;
                end
            end else begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 1) begin
                    m_diff[i] = 8'((m_a[i] - m_b[i]) & ((1 << w) - 1));
                    m_bo[i]   = (m_a[i] < m_b[i]);
                    sd        = sval(m_a[i], w) - sval(m_b[i], w);
                    m_ov[i]   = (sd < -(1 << (w - 1))) || (sd >= (1 << (w - 1)));
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk("ready", i, 32'(rdy[i]), 32'(m_left[i] == 0));
            chk("done",  i, 32'(dn[i]),  32'(m_left[i] == 1));
            chk("diff",  i, 32'(dv[i]),  32'(m_diff[i]));
            chk("borrow", i, 32'(bo[i]), 32'(m_bo[i]));
            chk("overflow", i, 32'(ov[i]), 32'(m_ov[i]));
        end
    end

    task automatic wait_ready(input int i);
        int n = 0;
        while (rdy[i] !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) timeout("wait_ready");
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, output int lat);
        wait_ready(0);
        av[0] = x;
        bv[0] = y;
        st[0] = 1'b1;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        av[0] = 8'($urandom);
        bv[0] = 8'($urandom);
        lat = 0;
        while (dn[0] !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 100) timeout("op8_done");
    endtask

    task automatic run_exh(input int i);
        int w = wid(i);
        st[i] = 1'b1;
        for (int x = 0; x < (1 << w); x++) begin
            for (int y = 0; y < (1 << w); y++) begin
                int n = 0;
                av[i] = 8'(x);
                bv[i] = 8'(y);
                @(negedge clk);
                while (rdy[i] !== 1'b1 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 50) timeout("exh_ready");
                @(posedge clk);
                #1;
            end
        end
        st[i] = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            av[i] = '0;
            bv[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_ready", 0, 32'(rdy[0]), 32'd1);
        chk("reset_diff",  0, 32'(dv[0]),  32'd0);

        op8(8'd200, 8'd55, lat);
        chk("t1_latency", 0, 32'(lat), 32'd8);
        chk("t1_diff",    0, 32'(dv[0]), 32'd145);
        chk("t1_borrow",  0, 32'(bo[0]), 32'd0);
        chk("t1_ovf",     0, 32'(ov[0]), 32'd0);

        op8(8'd10, 8'd20, lat);
        chk("t2a_diff",   0, 32'(dv[0]), 32'd246);
        chk("t2a_borrow", 0, 32'(bo[0]), 32'd1);
        op8(8'h80, 8'h01, lat);
        chk("t2b_diff",   0, 32'(dv[0]), 32'h7F);
        chk("t2b_ovf",    0, 32'(ov[0]), 32'd1);

        // start held high with operands churning during SHIFT
        wait_ready(0);
        st[0] = 1'b1;
        av[0] = 8'd33;
        bv[0] = 8'd77;
        @(posedge clk);
        #1;
        seen = 0;
        for (int c = 0; c < 14; c++) begin
            av[0] = 8'($urandom);
            bv[0] = 8'($urandom);
            if (dn[0] === 1'b1 && seen == 0) begin
                chk("t3_first_diff", 0, 32'(dv[0]), 32'd212);
                seen = 1;
            end
            @(posedge clk);
            #1;
        end
        st[0] = 1'b0;
        chk("t3_done_seen", 0, 32'(seen), 32'd1);
        wait_ready(0);

        // reset on the 4th SHIFT edge
        st[0] = 1'b1;
        av[0] = 8'd100;
        bv[0] = 8'd3;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t4_diff",  0, 32'(dv[0]), 32'd0);
        chk("t4_ready", 0, 32'(rdy[0]), 32'd1);
        chk("t4_done",  0, 32'(dn[0]), 32'd0);
        op8(8'd77, 8'd200, lat);
        chk("t4_new_diff", 0, 32'(dv[0]), 32'd133);
        chk("t4_new_ovf",  0, 32'(ov[0]), 32'd1);

        // reset and start on the same edge
        wait_ready(0);
        rst   = 1'b1;
        st[0] = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        st[0] = 1'b0;
        chk("t5_ready", 0, 32'(rdy[0]), 32'd1);
        repeat (12) @(posedge clk);
        #1;

        repeat (40) begin
            op8(8'($urandom), 8'($urandom), lat);
            chk("rand_latency", 0, 32'(lat), 32'd8);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        fork
            run_exh(1);
            run_exh(2);
        join
        repeat (10) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
